// File: rtl/pu_or1k_wb_arbiter.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave port.
// Ownership lasts a whole cyc; a watchdog aborts transfers the slave never ends.
module pu_or1k_wb_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int LW = $clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = DW / 8;
  localparam logic [CW-1:0] TLAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_ABORT,
    S_HOLD
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [LW-1:0]          r_last, w_last_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [LW-1:0]          w_win;
  logic [LW-1:0]          w_j;
  logic                   w_win_vld;
  logic                   w_own;
  logic                   w_stall;
  logic                   w_fire;
  logic                   w_rearb;

  assign w_own   = |r_grant;
  assign grant_o = r_grant;

  // Scan from the slot after the last owner; the first requester wins.
  always_comb begin
    int j;
    j         = 0;
    w_j       = '0;
    w_win     = '0;
    w_win_vld = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      j   = (int'(r_last) + i) % NUM_MASTERS;
      w_j = LW'(j);
      if (!w_win_vld && m_cyc_i[w_j]) begin
        w_win_vld = 1'b1;
        w_win     = w_j;
      end
    end
  end

  assign w_stall = (r_state == S_GRANT) & m_cyc_i[r_last] &
                   m_stb_i[r_last] & ~s_ack_i & ~s_err_i;
  assign w_fire  = (TIMEOUT != 0) && w_stall && (r_cnt == TLAST);

  always_comb begin
    w_cnt_nxt = '0;
    if (w_stall) begin
      w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_rearb     = 1'b0;
    unique case (r_state)
      S_IDLE: w_rearb = 1'b1;
      S_GRANT: begin
        if (!m_cyc_i[r_last]) w_rearb = 1'b1;
        else if (w_fire)      w_state_nxt = S_ABORT;
      end
      S_ABORT, S_HOLD: begin
        if (!m_cyc_i[r_last]) w_rearb = 1'b1;
        else                  w_state_nxt = S_HOLD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_rearb) begin
      if (w_win_vld) begin
        w_state_nxt = S_GRANT;
        w_grant_nxt = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_win;
        w_last_nxt  = w_win;
      end else begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= LW'(NUM_MASTERS - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Slave side follows the owner combinationally; abort masks the slave.
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    m_dat_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    timeout_o = 1'b0;
    if (w_own) begin
      s_adr_o = m_adr_i[r_last*AW +: AW];
      s_dat_o = m_dat_i[r_last*DW +: DW];
      s_sel_o = m_sel_i[r_last*SW +: SW];
      s_we_o  = m_we_i[r_last];
      s_cti_o = m_cti_i[r_last*3 +: 3];
      s_bte_o = m_bte_i[r_last*2 +: 2];
      m_dat_o = s_dat_i;
    end
    unique case (r_state)
      S_GRANT: begin
        s_cyc_o         = m_cyc_i[r_last];
        s_stb_o         = m_stb_i[r_last];
        m_ack_o[r_last] = s_ack_i & ~s_err_i;
        m_err_o[r_last] = s_err_i;
      end
      S_ABORT: begin
        m_err_o[r_last] = 1'b1;
        timeout_o       = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_pu_or1k_wb_arbiter.sv
// Scoreboard bench for pu_or1k_wb_arbiter: expected grants and responses are
// queued by the stimulus and popped by a monitor whenever the DUT shows them.
module tb_pu_or1k_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*4-1:0]  m_sel;
  logic [N-1:0]    m_we, m_cyc, m_stb;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, grant_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [3:0]      s_sel_o;
  logic            s_we_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic            s_cyc_o, s_stb_o, timeout_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i, s_err_i;

  int total = 0;
  int bad   = 0;
  logic [2:0]  gq[$];
  logic [38:0] rq[$];
  logic [2:0]  prev_g = 3'b000;

  always #5 clk = ~clk;

  pu_or1k_wb_arbiter #(
    .NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(16)
  ) u_dut (
    .wb_clk_i (clk),     .wb_rst_ni(rst_n),
    .m_adr_i  (m_adr),   .m_dat_i  (m_dat),
    .m_sel_i  (m_sel),   .m_we_i   (m_we),
    .m_cyc_i  (m_cyc),   .m_stb_i  (m_stb),
    .m_cti_i  (m_cti),   .m_bte_i  (m_bte),
    .m_dat_o  (m_dat_o), .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o), .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o), .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),  .s_cti_o  (s_cti_o),
    .s_bte_o  (s_bte_o), .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o), .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i), .s_err_i  (s_err_i),
    .grant_o  (grant_o), .timeout_o(timeout_o)
  );

  always @(negedge clk) begin
    logic [2:0]  eg;
    logic [38:0] er;
    if (grant_o !== prev_g) begin
      total++;
      if (gq.size() == 0) begin
        bad++;
        $display("FAIL grant_unexpected got=%b exp=none", grant_o);
      end else begin
        eg = gq.pop_front();
        if (grant_o !== eg) begin
          bad++;
          $display("FAIL grant_seq got=%b exp=%b", grant_o, eg);
        end
      end
      prev_g = grant_o;
    end
    if (|{m_ack_o, m_err_o, timeout_o}) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected ack=%b err=%b to=%b",
                 m_ack_o, m_err_o, timeout_o);
      end else begin
        er = rq.pop_front();
        if ({m_ack_o, m_err_o, timeout_o, m_dat_o} !== er) begin
          bad++;
          $display("FAIL resp got=%b_%b_%b_%h exp=%b_%b_%b_%h",
                   m_ack_o, m_err_o, timeout_o, m_dat_o,
                   er[38:36], er[35:33], er[32], er[31:0]);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic set_m(int k, logic [31:0] a, logic [31:0] d,
                       logic we, logic [2:0] cti);
    m_adr[k*AW +: AW] = a;
    m_dat[k*DW +: DW] = d;
    m_sel[k*4 +: 4]   = 4'hF;
    m_we[k]           = we;
    m_cti[k*3 +: 3]   = cti;
    m_cyc[k]          = 1'b1;
    m_stb[k]          = 1'b1;
  endtask

  task automatic drop(int k);
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
  endtask

  task automatic wait_grant(int k);
    int n = 0;
    while (!grant_o[k] && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (!grant_o[k]) begin
      bad++;
      $display("FAIL wait_grant%0d got=%b exp_bit=1", k, grant_o);
    end
  endtask

  task automatic single(int k, logic [31:0] d, logic [2:0] nxt);
    logic [2:0] oh;
    oh = 3'b001 << k;
    wait_grant(k);
    s_dat_i = d;
    s_ack_i = 1'b1;
    rq.push_back({oh, 3'b000, 1'b0, d});
    tick();
    s_ack_i = 1'b0;
    gq.push_back(nxt);
    drop(k);
  endtask

  initial begin
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
    m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_cyc", {s_cyc_o, s_stb_o}, 0);
    chk("rst_resp", {m_ack_o, m_err_o, timeout_o}, 0);
    tick(2);
    rst_n = 1'b1;
    tick();

    // single write from master 1
    gq.push_back(3'b010);
    set_m(1, 32'h100, 32'hDEADBEEF, 1'b1, 3'b000);
    #1 chk("t1_cyc_pre", s_cyc_o, 0);
    tick();
    chk("t1_cyc", s_cyc_o, 1);
    chk("t1_grant", grant_o, 3'b010);
    chk("t1_adr", s_adr_o, 32'h100);
    chk("t1_dat", s_dat_o, 32'hDEADBEEF);
    chk("t1_we_sel", {s_we_o, s_sel_o}, 5'h1F);
    tick();
    s_ack_i = 1'b1;
    rq.push_back({3'b010, 3'b000, 1'b0, 32'h0});
    tick();
    s_ack_i = 1'b0;
    gq.push_back(3'b000);
    drop(1);
    tick(2);

    // fairness after a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    gq.push_back(3'b001);
    for (int k = 0; k < N; k++) set_m(k, 32'h10 * k, 32'h0, 1'b0, 3'b000);
    single(0, 32'hA0, 3'b010);
    tick();
    set_m(0, 32'h0, 32'h0, 1'b0, 3'b000);
    single(1, 32'hA1, 3'b100);
    single(2, 32'hA2, 3'b001);
    single(0, 32'hA3, 3'b000);
    tick(2);

    // burst lock on master 0, master 2 requests at beat 1
    gq.push_back(3'b001);
    gq.push_back(3'b100);
    set_m(0, 32'h200, 32'h0, 1'b0, 3'b010);
    wait_grant(0);
    for (int b = 0; b < 4; b++) begin
      m_cti[2:0] = (b == 3) ? 3'b111 : 3'b010;
      s_dat_i = 32'hB000_0000 + b;
      s_ack_i = 1'b1;
      rq.push_back({3'b001, 3'b000, 1'b0, 32'hB000_0000 + b});
      if (b == 1) set_m(2, 32'h300, 32'h0, 1'b0, 3'b000);
      #1;
      chk("t3_lock", grant_o, 3'b001);
      chk("t3_cti", s_cti_o, (b == 3) ? 3'b111 : 3'b010);
      tick();
    end
    s_ack_i = 1'b0;
    drop(0);
    #1 chk("t3_hold", grant_o, 3'b001);
    tick();
    chk("t3_next", grant_o, 3'b100);
    single(2, 32'hC2, 3'b000);
    tick(2);

    // watchdog, TIMEOUT = 16
    gq.push_back(3'b010);
    s_dat_i = 32'h0;
    set_m(1, 32'h400, 32'h0, 1'b0, 3'b000);
    rq.push_back({3'b000, 3'b010, 1'b1, 32'h0});
    tick();
    chk("t4_grant", grant_o, 3'b010);
    tick(15);
    chk("t4_pre_err", {m_err_o, timeout_o}, 0);
    chk("t4_pre_cyc", s_cyc_o, 1);
    tick();
    chk("t4_err", m_err_o, 3'b010);
    chk("t4_to", timeout_o, 1);
    chk("t4_scyc", {s_cyc_o, s_stb_o}, 0);
    s_ack_i = 1'b1;
    set_m(0, 32'h500, 32'h0, 1'b0, 3'b000);
    tick();
    chk("t4_pulse", {m_ack_o, m_err_o, timeout_o, s_cyc_o}, 0);
    s_ack_i = 1'b0;
    tick(3);
    chk("t4_held", grant_o, 3'b010);
    gq.push_back(3'b001);
    drop(1);
    tick();
    chk("t4_regrant", grant_o, 3'b001);

    // err wins over ack
    s_dat_i = 32'h5A5A;
    s_ack_i = 1'b1;
    s_err_i = 1'b1;
    rq.push_back({3'b000, 3'b001, 1'b0, 32'h5A5A});
    #1;
    chk("t5_ack", m_ack_o, 0);
    chk("t5_err", m_err_o, 3'b001);
    tick();
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    gq.push_back(3'b000);
    drop(0);
    tick(2);

    // async reset mid-burst
    gq.push_back(3'b001);
    set_m(0, 32'h600, 32'h0, 1'b0, 3'b010);
    wait_grant(0);
    for (int b = 0; b < 2; b++) begin
      s_dat_i = 32'hD0 + b;
      s_ack_i = 1'b1;
      rq.push_back({3'b001, 3'b000, 1'b0, 32'hD0 + b});
      tick();
    end
    s_ack_i = 1'b0;
    gq.push_back(3'b000);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cyc", {s_cyc_o, s_stb_o}, 0);
    chk("t6_grant", grant_o, 0);
    set_m(1, 32'h700, 32'h0, 1'b0, 3'b000);
    gq.push_back(3'b001);
    tick(2);
    rst_n = 1'b1;
    tick();
    chk("t6_first", grant_o, 3'b001);
    single(0, 32'hE0, 3'b010);
    single(1, 32'hE1, 3'b000);
    tick(3);

    chk("gq_empty", gq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
